// File: rtl/axi_burst_write_engine.sv
// axi_burst_write_engine: AXI4 write master splitting one command into 4 KB-safe INCR bursts with outstanding-response tracking
module axi_burst_write_engine #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_beats,
    input  logic [DATA_W-1:0]     s_data,
    input  logic [DATA_W/8-1:0]   s_strb,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CW    = $clog2(MAX_OUTST + 1);
    localparam int PW    = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
    localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_OUTST - 1);
    localparam logic [CW-1:0] OUTST_MAX = CW'(MAX_OUTST);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, awaddr_q, awaddr_d, src_addr;
    logic [LEN_W-1:0]    rem_q, rem_d, src_rem;
    logic [7:0]          awlen_q, awlen_d;
    logic                awvalid_q, awvalid_d, bready_q;
    logic [1:0]          status_q, status_d;
    logic [CW-1:0]       outst_q, outst_d, fcnt_q, fcnt_d;
    logic [PW-1:0]       wptr_q, rptr_q;
    logic [7:0]          fifo_q [MAX_OUTST];
    logic [7:0]          beat_q;
    logic [12:0]         page_beats;
    logic [31:0]         len;
    logic                accept, load, aw_hs, w_hs, b_hs, w_active, wlast_hs;

    assign accept        = cmd_valid & cmd_ready;
    assign aw_hs         = awvalid_q & m_axi_awready;
    assign b_hs          = bready_q & m_axi_bvalid;
    assign w_active      = fcnt_q != '0;
    assign m_axi_wvalid  = w_active & s_valid;
    assign s_ready       = w_active & m_axi_wready;
    assign m_axi_wlast   = w_active & (beat_q == fifo_q[rptr_q]);
    assign w_hs          = m_axi_wvalid & m_axi_wready;
    assign wlast_hs      = w_hs & m_axi_wlast;
    assign m_axi_wdata   = s_data;
    assign m_axi_wstrb   = s_strb;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awsize  = 3'(OFF_W);
    assign m_axi_awburst = 2'b01;
    assign m_axi_bready  = bready_q;
    assign status        = status_q;

    // Size the next burst: addr_q/rem_q always describe the burst after the one on AW
    always_comb begin
        src_addr   = (state_q == IDLE) ? cmd_addr : addr_q;
        src_rem    = (state_q == IDLE) ? cmd_beats : rem_q;
        page_beats = (13'h1000 - {1'b0, src_addr[11:0]}) >> OFF_W;
        len        = 32'(src_rem);
        len        = (len > 32'(MAX_BURST)) ? 32'(MAX_BURST) : len;
        len        = (len > 32'(page_beats)) ? 32'(page_beats) : len;
    end

    // Counter, AW and status next-state; a new AW is loaded on accept or as soon as the previous one retires
    always_comb begin
        outst_d   = outst_q + CW'(aw_hs) - CW'(b_hs);
        fcnt_d    = fcnt_q + CW'(aw_hs) - CW'(wlast_hs);
        load      = (accept & (cmd_beats != '0)) |
                    ((state_q == ISSUE) & (rem_q != '0) & (~awvalid_q | aw_hs) &
                     (outst_d < OUTST_MAX) & (fcnt_d < OUTST_MAX));
        addr_d    = load ? src_addr + ADDR_W'(len << OFF_W) : addr_q;
        rem_d     = load ? src_rem - LEN_W'(len) : rem_q;
        awaddr_d  = load ? src_addr : awaddr_q;
        awlen_d   = load ? 8'(len - 32'd1) : awlen_q;
        awvalid_d = load | (awvalid_q & ~aw_hs);
        status_d  = accept ? 2'b00 : (b_hs && (m_axi_bresp > status_q)) ? m_axi_bresp : status_q;
    end

    // FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state; DRAIN looks at next-cycle counts so done follows the last handshake by one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ((cmd_beats == '0) ? FINISH : ISSUE) : IDLE;
            ISSUE:   state_d = (aw_hs && rem_q == '0) ? DRAIN : ISSUE;
            DRAIN:   state_d = (fcnt_d == '0 && outst_d == '0) ? FINISH : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cmd_ready = state_q == IDLE;
        busy      = state_q != IDLE;
        done      = state_q == FINISH;
    end

    // AW, B and bookkeeping registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q    <= '0;
            rem_q     <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awvalid_q <= 1'b0;
            status_q  <= 2'b00;
            outst_q   <= '0;
            bready_q  <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awvalid_q <= awvalid_d;
            status_q  <= status_d;
            outst_q   <= outst_d;
            bready_q  <= outst_d != '0;
        end
    end

    // Burst FIFO pointers and W beat counter
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
            beat_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            if (aw_hs) wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
            if (wlast_hs) rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
            if (w_hs) beat_q <= m_axi_wlast ? 8'd0 : beat_q + 8'd1;
        end
    end

    // Burst FIFO storage holds awlen of each issued burst until its W beats finish
    always_ff @(posedge aclk) begin
        if (aw_hs) fifo_q[wptr_q] <= awlen_q;
    end
endmodule

// File: tb/tb_axi_burst_write_engine.sv
// tb_axi_burst_write_engine: directed checks of burst splitting, outstanding cap, backpressure, error merge and reset
module tb_axi_burst_write_engine;
    localparam int ADDR_W = 32, DATA_W = 64, MAX_BURST = 16, LEN_W = 16, MAX_OUTST = 4;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              cmd_valid, cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_beats;
    logic [DATA_W-1:0] s_data;
    logic [7:0]        s_strb;
    logic              s_valid, s_ready, busy, done;
    logic [1:0]        status;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst;
    logic              m_axi_awvalid, m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [7:0]        m_axi_wstrb;
    logic              m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid, m_axi_bready;

    axi_burst_write_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .s_data(s_data), .s_strb(s_strb), .s_valid(s_valid), .s_ready(s_ready),
        .busy(busy), .done(done), .status(status),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, aw_n, w_n, wl_n, b_n, b_limit, done_cyc, last_b_cyc, last_wl_cyc, burst_beats;
    int src_idx, src_total;
    logic [31:0] aw_addr_log [$];
    logic [7:0]  aw_len_log [$];
    int          wl_pos [$];
    logic [63:0] data_base;
    logic [1:0]  bresp_tab [8];
    bit          rnd;
    logic        pv_wait, first_aw, first_done;
    logic [1:0]  first_status;
    logic [31:0] pv_addr;
    logic [7:0]  pv_len;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] aw_a(input int i);
        return (i < aw_addr_log.size()) ? aw_addr_log[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [7:0] aw_l(input int i);
        return (i < aw_len_log.size()) ? aw_len_log[i] : 8'hEE;
    endfunction

    function automatic int wl_p(input int i);
        return (i < wl_pos.size()) ? wl_pos[i] : -1;
    endfunction

    // Monitor: logs handshakes mid-cycle and checks data order, burst sizes and the AW hold rule
    always @(negedge aclk) begin
        cyc++;
        if (!aresetn) pv_wait = 1'b0;
        else begin
            if (pv_wait)
                check("aw_hold", 64'({m_axi_awvalid, m_axi_awaddr, m_axi_awlen}), 64'({1'b1, pv_addr, pv_len}));
            pv_wait = m_axi_awvalid & ~m_axi_awready;
            pv_addr = m_axi_awaddr;
            pv_len  = m_axi_awlen;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_log.push_back(m_axi_awaddr);
                aw_len_log.push_back(m_axi_awlen);
                aw_n++;
            end
            if (s_valid && s_ready) src_idx++;
            if (m_axi_wvalid && m_axi_wready) begin
                check("wdata", m_axi_wdata, data_base + 64'(w_n));
                w_n++;
                burst_beats++;
                if (m_axi_wlast) begin
                    check("burst_beats", 64'(burst_beats), (wl_n < aw_len_log.size()) ? 64'(aw_len_log[wl_n]) + 64'd1 : 64'd0);
                    wl_pos.push_back(w_n);
                    wl_n++;
                    burst_beats = 0;
                    last_wl_cyc = cyc;
                end
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_n++;
                last_b_cyc = cyc;
            end
            if (done) done_cyc = cyc;
        end
    end

    // Slave and stream source: drive inputs just after each rising edge
    always @(posedge aclk) begin
        #1;
        m_axi_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        s_valid       = (src_idx < src_total) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
        s_data        = data_base + 64'(src_idx);
        s_strb        = 8'hFF;
        m_axi_bvalid  = (wl_n > b_n) && (b_n < b_limit);
        m_axi_bresp   = bresp_tab[b_n[2:0]];
    end

    task automatic start_cmd(input logic [31:0] a, input logic [15:0] n, input logic [63:0] base);
        @(posedge aclk); #2;
        aw_n = 0; w_n = 0; wl_n = 0; b_n = 0; burst_beats = 0; done_cyc = -1;
        aw_addr_log.delete(); aw_len_log.delete(); wl_pos.delete();
        src_idx = 0; src_total = int'(n); data_base = base;
        cmd_valid = 1'b1; cmd_addr = a; cmd_beats = n;
        @(posedge aclk); #2;
        cmd_valid = 1'b0;
        @(negedge aclk); #1;
        first_aw = m_axi_awvalid;
        first_done = done;
        first_status = status;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit && done_cyc < 0; i++) begin
            @(negedge aclk); #1;
        end
        check({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
        @(negedge aclk); #1;
        check({tag, "_idle_after_done"}, 64'({busy, cmd_ready, done}), 64'b010);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_awvalid"}, 64'(m_axi_awvalid), 64'd0);
        check({tag, "_wvalid"}, 64'(m_axi_wvalid), 64'd0);
        check({tag, "_wlast"}, 64'(m_axi_wlast), 64'd0);
        check({tag, "_bready"}, 64'(m_axi_bready), 64'd0);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_busy_done"}, 64'({busy, done}), 64'd0);
        check({tag, "_status"}, 64'(status), 64'd0);
        check({tag, "_awaddr"}, 64'(m_axi_awaddr), 64'd0);
        check({tag, "_awlen"}, 64'(m_axi_awlen), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_size_burst"}, 64'({m_axi_awsize, m_axi_awburst}), 64'({3'd3, 2'b01}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
        s_valid = 1'b0; s_data = '0; s_strb = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        src_idx = 0; src_total = 0; data_base = '0; rnd = 1'b0; b_limit = 1000;
        aw_n = 0; w_n = 0; wl_n = 0; b_n = 0; done_cyc = -1; burst_beats = 0;
        last_b_cyc = 0; last_wl_cyc = 0; pv_wait = 1'b0; pv_addr = '0; pv_len = '0;
        for (int i = 0; i < 8; i++) bresp_tab[i] = 2'b00;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_reset("por");
        @(posedge aclk); #2;
        aresetn = 1'b1;

        // multi-burst split
        start_cmd(32'h1000, 16'd40, 64'h100);
        check("t1_first_aw", 64'(first_aw), 64'd1);
        wait_done("t1", 500);
        check("t1_aw_n", 64'(aw_n), 64'd3);
        check("t1_aw0", 64'({aw_a(0), aw_l(0)}), 64'({32'h1000, 8'd15}));
        check("t1_aw1", 64'({aw_a(1), aw_l(1)}), 64'({32'h1080, 8'd15}));
        check("t1_aw2", 64'({aw_a(2), aw_l(2)}), 64'({32'h1100, 8'd7}));
        check("t1_wlast_pos", 64'({16'(wl_p(0)), 16'(wl_p(1)), 16'(wl_p(2))}), 64'({16'd16, 16'd32, 16'd40}));
        check("t1_w_n", 64'(w_n), 64'd40);
        check("t1_status", 64'(status), 64'd0);
        check("t1_done_latency", 64'(done_cyc), 64'(((last_b_cyc > last_wl_cyc) ? last_b_cyc : last_wl_cyc) + 1));

        // 4 KB crossing
        start_cmd(32'h0FF0, 16'd8, 64'h2000);
        wait_done("t2", 300);
        check("t2_aw_n", 64'(aw_n), 64'd2);
        check("t2_aw0", 64'({aw_a(0), aw_l(0)}), 64'({32'h0FF0, 8'd1}));
        check("t2_aw1", 64'({aw_a(1), aw_l(1)}), 64'({32'h1000, 8'd5}));
        check("t2_w_n", 64'(w_n), 64'd8);

        // outstanding cap
        b_limit = 0;
        start_cmd(32'h3000, 16'd96, 64'h3000);
        repeat (100) @(negedge aclk);
        #1;
        check("t3_aw_capped", 64'(aw_n), 64'd4);
        check("t3_awvalid_low", 64'(m_axi_awvalid), 64'd0);
        check("t3_w_stalled", 64'(w_n), 64'd64);
        b_limit = 1;
        repeat (40) @(negedge aclk);
        #1;
        check("t3_aw_after_one_b", 64'(aw_n), 64'd5);
        check("t3_awvalid_low2", 64'(m_axi_awvalid), 64'd0);
        check("t3_b_n", 64'(b_n), 64'd1);
        b_limit = 1000;
        wait_done("t3", 1000);
        check("t3_aw_total", 64'(aw_n), 64'd6);
        check("t3_w_total", 64'(w_n), 64'd96);

        // backpressure on AW, W and the stream
        rnd = 1'b1;
        start_cmd(32'h4000, 16'd50, 64'h4000_0000);
        wait_done("t4", 3000);
        rnd = 1'b0;
        check("t4_aw_n", 64'(aw_n), 64'd4);
        check("t4_lens", 64'({aw_l(0), aw_l(1), aw_l(2), aw_l(3)}), 64'({8'd15, 8'd15, 8'd15, 8'd1}));
        check("t4_addr3", 64'(aw_a(3)), 64'h4180);
        check("t4_w_n", 64'(w_n), 64'd50);
        check("t4_wl_n", 64'(wl_n), 64'd4);

        // error merge
        bresp_tab[0] = 2'b00; bresp_tab[1] = 2'b10; bresp_tab[2] = 2'b00;
        start_cmd(32'h5000, 16'd48, 64'h5000);
        wait_done("t5a", 500);
        check("t5a_aw_n", 64'(aw_n), 64'd3);
        check("t5a_status", 64'(status), 64'd2);
        bresp_tab[0] = 2'b11; bresp_tab[1] = 2'b00; bresp_tab[2] = 2'b00;
        start_cmd(32'h6000, 16'd32, 64'h6000);
        wait_done("t5b", 500);
        check("t5b_status", 64'(status), 64'd3);
        bresp_tab[0] = 2'b00;
        start_cmd(32'h7000, 16'd4, 64'h7000);
        check("t5c_status_cleared", 64'(first_status), 64'd0);
        wait_done("t5c", 200);
        check("t5c_status", 64'(status), 64'd0);

        // zero length
        start_cmd(32'h9000, 16'd0, 64'h0);
        check("t6_zero_done_next", 64'({first_done, first_aw}), 64'b10);
        wait_done("t6z", 10);
        check("t6_zero_no_aw", 64'(aw_n), 64'd0);

        // reset mid-burst, then a normal command
        start_cmd(32'h8000, 16'd64, 64'h8000);
        repeat (10) @(negedge aclk);
        @(posedge aclk); #2;
        aresetn = 1'b0;
        @(negedge aclk);
        check_reset("mid");
        @(posedge aclk); #2;
        aresetn = 1'b1;
        start_cmd(32'h2000, 16'd4, 64'hA000);
        wait_done("t6r", 200);
        check("t6r_aw", 64'({aw_a(0), aw_l(0)}), 64'({32'h2000, 8'd3}));
        check("t6r_aw_n", 64'(aw_n), 64'd1);
        check("t6r_w_n", 64'(w_n), 64'd4);
        check("t6r_status", 64'(status), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_burst_write_engine.md
# axi_burst_write_engine

Parametrised AXI4 write master that accepts a single (address, beat count) command and streams user data to memory. It splits the transfer into INCR bursts that never exceed MAX_BURST beats and never cross a 4 KB boundary. Up to MAX_OUTST bursts may await write responses at once. It sits between a user datapath (valid/ready command and data stream) and the AXI interconnect, and supersedes the single-burst, one-transaction-at-a-time master.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width; power of 2, 32..1024
- MAX_BURST, 16, max beats per burst; power of 2, 1..256
- LEN_W, 16, width of total beat count
- MAX_OUTST, 4, max bursts issued on AW and not yet answered on B; 1..16

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  ADDR_W  start byte address; must be aligned to DATA_W/8
- cmd_beats  in  LEN_W  total beats; 0 is legal (no-op)
- s_data  in  DATA_W  write data stream
- s_strb  in  DATA_W/8  byte strobes
- s_valid  in  1  stream valid
- s_ready  out  1  stream ready
- busy  out  1  high from command accept until done
- done  out  1  one-cycle completion pulse
- status  out  2  worst BRESP of the command; held until next accept
- m_axi_awaddr  out  ADDR_W  burst address
- m_axi_awlen  out  8  beats-1
- m_axi_awsize  out  3  constant $clog2(DATA_W/8)
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  DATA_W
- m_axi_wstrb  out  DATA_W/8
- m_axi_wlast  out  1
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1

## Operation
- States: IDLE, ISSUE, DRAIN, FINISH.
- **IDLE:** cmd_ready=1. An accept latches addr, rem=cmd_beats and status=0, then moves to ISSUE.
  - cmd_beats=0: go to FINISH with no AXI traffic.
- **ISSUE, burst sizing:**
  - BYTES=DATA_W/8.
  - len = min(rem, MAX_BURST, (4096-addr[11:0])/BYTES).
  - awlen=len-1; awaddr=addr. Both registered and held stable while awvalid=1.
- **ISSUE, AW handshake:**
  - Push len into an internal burst FIFO of depth MAX_OUTST.
  - outst++, addr+=len*BYTES (modulo 2^ADDR_W), rem-=len.
  - When rem reaches 0, go to DRAIN.
  - awvalid is deasserted while outst==MAX_OUTST.
- **W path (runs concurrently):**
  - Pops the burst FIFO head and counts beats.
  - wvalid=s_valid and s_ready=wready only while a burst is active.
  - wdata/wstrb pass s_data/s_strb through.
  - wlast=1 on the final beat of each burst; the FIFO pops on the wlast handshake.
  - W never leads its AW: no active burst means wvalid=0 and s_ready=0.
- **B path:**
  - bready=1 whenever outst>0.
  - Each bvalid&bready: outst--, status=max(status,bresp).
  - A simultaneous AW and B handshake leaves outst unchanged.
- **DRAIN:** wait until the FIFO is empty and outst==0, then go to FINISH.
- **FINISH:** done=1 for one cycle, busy=0 next cycle, return to IDLE.
- **Reset mid-operation:** immediate return to IDLE with the FIFO and counters cleared. No resumption; the interconnect is reset alongside.

## Timing
- **Reset values:**
  - 0: awvalid, wvalid, wlast, bready, s_ready, busy, done, status, awaddr, awlen.
  - cmd_ready=1.
  - awsize and awburst are constants.
- **Latency:**
  - First awvalid appears the cycle after command accept.
  - A subsequent awvalid appears the cycle after the previous AW handshake, if outst<MAX_OUTST.
  - done fires the cycle after the last of {final B handshake, final wlast handshake}.
  - cmd_beats=0: done the cycle after accept.
- **Combinational paths:**
  - s_valid→wvalid and wready→s_ready; no W-path register stage.
  - The AW and B paths are fully registered.
- **Hold rule:** awvalid, once high, stays high with awaddr/awlen stable until awready.
- **Throughput:** one W beat per cycle when s_valid and wready are both continuously high, including across burst boundaries (next FIFO entry already present).

## Test plan
1. **Multi-burst split:** DATA_W=64, MAX_BURST=16, addr 0x1000, beats 40.
   - Expect bursts awaddr/awlen 0x1000/15, 0x1080/15, 0x1100/7.
   - Expect wlast on beats 16, 32, 40; done; status=00.
2. **4 KB crossing:** addr 0x0FF0, beats 8.
   - Expect awaddr/awlen 0x0FF0/1, then 0x1000/5; no burst spans 0x1000.
3. **Outstanding cap:** MAX_OUTST=4, bvalid held low, beats 96.
   - Expect exactly 4 AW handshakes, then awvalid=0.
   - Releasing one B yields exactly one more AW.
4. **Backpressure:** random wready and s_valid gaps, beats 50, incrementing data.
   - Expect AXI data identical and in order; each burst's beat count equals its awlen+1.
5. **Error merge:** three bursts with BRESP 00, 10, 00 → status=10.
   - A separate run with BRESP 11, 00 → status=11.
   - status is cleared on the next accept.
6. **Zero length and reset:** cmd_beats=0 → done the next cycle, no AW.
   - Assert aresetn low mid-burst → all outputs at reset values.
   - After release, a new command of 4 beats at 0x2000 completes normally.
